pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the next generation of the inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). A global stall becomes local backpressure, so the stage runs at full throughput, preserves order and never drops an accepted beat. It also supports a synchronous flush that inserts a bubble with a configurable control word.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_entry_reg.sv | 51 +++++
 rtl/pipe_stage_skid.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants and types for the skid-buffered pipeline
//               stage: occupancy encoding, default bubble control word and
//               the {ctrl, data} beat layout for the default configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Occupancy encoding presented on occ_o.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Default payload widths and bubble control word. The bubble is kept as
    // an integer so it can be cast to whatever CTRL_W an instance uses.
    localparam int PIPE_DATA_W      = 32;
    localparam int PIPE_CTRL_W      = 8;
    localparam int PIPE_CTRL_BUBBLE = 0;

    // Beat layout for the default widths; instances with other widths
    // declare the same {ctrl, data} packing locally from their parameters.
    typedef struct packed {
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_DATA_W-1:0] data;
    } pipe_beat_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_entry_reg
// Description : One storage entry (valid + ctrl + data) of the pipeline
//               stage. Clear invalidates the entry and forces ctrl to the
//               bubble word while data keeps its value; clear wins over load.
// Ports       : clk_i, rst_i (async, active-low), clear_i, load_i,
//               ctrl_i/data_i (load value), valid_o/ctrl_o/data_o (state).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
            r_data  <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_ctrl  <= ctrl_i;
            r_data  <= data_i;
        end
    end

    assign valid_o = r_valid;
    assign ctrl_o  = r_ctrl;
    assign data_o  = r_data;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Pipeline stage register with valid/ready handshake and a
//               two-entry (main + skid) buffer. Full throughput, strict FIFO
//               order, registered in_ready_o, synchronous flush to bubble.
// Ports       : clk_i, rst_i (async, active-low), flush_i,
//               in_valid_i/in_ready_o/in_data_i/in_ctrl_i   (upstream),
//               out_valid_o/out_ready_i/out_data_o/out_ctrl_o (downstream),
//               occ_o (0 empty, 1 one, 2 full).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = PIPE_DATA_W,
    parameter int                CTRL_W      = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o
);

    logic [1:0]        r_occ;
    logic [1:0]        w_occ_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;

    // in_ready_o decodes registered state only, so out_ready_i never reaches it.
    assign in_ready_o = (r_occ != OCC_FULL);
    assign w_in_fire  = in_valid_i && in_ready_o;
    assign w_out_fire = out_valid_o && out_ready_i;

    always_comb begin
        w_occ_nxt    = r_occ;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush_i) begin
            // Flush beats any transfer; an incoming beat is simply dropped.
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
            w_occ_nxt    = OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                        w_occ_nxt   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_skid_load = 1'b1;
                        w_occ_nxt   = OCC_FULL;
                    end else if (w_out_fire && !w_in_fire) begin
                        w_main_clear = 1'b1;
                        w_occ_nxt    = OCC_EMPTY;
                    end else if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (w_out_fire) begin
                        w_main_load  = 1'b1;
                        w_skid_clear = 1'b1;
                        w_occ_nxt    = OCC_ONE;
                    end
                end
                default: w_occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    // Main refills from skid whenever skid holds the older beat.
    assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : in_ctrl_i;
    assign w_main_data_d = w_skid_valid ? w_skid_data : in_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    pipe_entry_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_main_clear),
        .load_i  (w_main_load),
        .ctrl_i  (w_main_ctrl_d),
        .data_i  (w_main_data_d),
        .valid_o (out_valid_o),
        .ctrl_o  (out_ctrl_o),
        .data_o  (out_data_o)
    );

    pipe_entry_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_skid_clear),
        .load_i  (w_skid_load),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (w_skid_valid),
        .ctrl_o  (w_skid_ctrl),
        .data_o  (w_skid_data)
    );

    assign occ_o = r_occ;

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. A capacity-2 queue
//               model predicts occupancy, handshake and output beats; a
//               second instance covers a wide/narrow parameter set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam logic [7:0] C_BUB  = 8'hA5;
    localparam logic [2:0] C_BUBW = 3'b101;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [1:0]  occ;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [63:0] w_in_data, w_out_data;
    logic [2:0]  w_in_ctrl, w_out_ctrl;
    logic [1:0]  w_occ;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  c;
        logic [31:0] d;
    } beat_t;
    beat_t q[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(C_BUB)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_ctrl_o(out_ctrl), .occ_o(occ)
    );

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(3), .CTRL_BUBBLE(C_BUBW)) dut_w (
        .clk_i(clk), .rst_i(rst_i), .flush_i(w_flush),
        .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
        .in_data_i(w_in_data), .in_ctrl_i(w_in_ctrl),
        .out_valid_o(w_out_valid), .out_ready_i(w_out_ready),
        .out_data_o(w_out_data), .out_ctrl_o(w_out_ctrl), .occ_o(w_occ)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the main DUT against the queue model.
    task automatic check_outputs();
        check_eq("occ", 64'(occ), 64'(q.size()));
        check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("out_data", 64'(out_data), 64'(q[0].d));
            check_eq("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
        end else begin
            check_eq("out_ctrl_bubble", 64'(out_ctrl), 64'(C_BUB));
        end
    endtask

    // Model of one clock edge: flush empties; otherwise pop if consumed,
    // push if accepted (both decided on the pre-edge occupancy).
    task automatic model_step(input logic v, input logic [31:0] d, input logic [7:0] c,
                              input logic ordy, input logic fl);
        bit of, inf;
        if (fl) begin
            q.delete();
        end else begin
            of  = (q.size() > 0) && ordy;
            inf = v && (q.size() < 2);
            if (of) void'(q.pop_front());
            if (inf) q.push_back('{c: c, d: d});
        end
    endtask

    // Called at a negedge: drive inputs, step the model at the edge, check.
    task automatic do_cycle(input logic v, input logic [31:0] d, input logic [7:0] c,
                            input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_step(v, d, c, ordy, fl);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 1;
        w_flush = 0; w_in_valid = 0; w_in_data = '0; w_in_ctrl = '0; w_out_ready = 1;

        repeat (3) @(negedge clk);
        check_eq("rst_out_data", 64'(out_data), 64'h0);
        check_outputs();
        rst_i = 1'b1;
        @(negedge clk);
        check_outputs();
        check_eq("rst_out_data_after", 64'(out_data), 64'h0);

        // Wide instance: bubble after reset, full-width pass, bubble after flush.
        check_eq("w_rst_ctrl", 64'(w_out_ctrl), 64'(C_BUBBW_ext()));
        check_eq("w_rst_occ", 64'(w_occ), 64'h0);
        check_eq("w_rst_data", w_out_data, 64'h0);
        w_in_valid = 1; w_in_data = 64'hFEDC_BA98_7654_3210; w_in_ctrl = 3'b010;
        @(negedge clk);
        w_in_valid = 0;
        check_eq("w_valid", 64'(w_out_valid), 64'h1);
        check_eq("w_data", w_out_data, 64'hFEDC_BA98_7654_3210);
        check_eq("w_ctrl", 64'(w_out_ctrl), 64'h2);
        w_out_ready = 0; w_flush = 1;
        @(negedge clk);
        w_flush = 0;
        check_eq("w_flush_valid", 64'(w_out_valid), 64'h0);
        check_eq("w_flush_ctrl", 64'(w_out_ctrl), 64'(C_BUBBW_ext()));
        check_eq("w_flush_occ", 64'(w_occ), 64'h0);

        // Streaming 0x100..0x107 with the sink always ready.
        for (int i = 0; i < 8; i++) do_cycle(1, 32'h100 + 32'(i), 8'(i), 1, 0);
        do_cycle(0, 0, 0, 1, 0);

        // Backpressure: stall the sink while the source keeps offering.
        for (int i = 0; i < 3; i++) do_cycle(1, 32'h200 + 32'(i), 8'h10, 1, 0);
        for (int i = 3; i < 7; i++) do_cycle(1, 32'h200 + 32'(i), 8'h11, 0, 0);
        for (int i = 7; i < 12; i++) do_cycle(1, 32'h200 + 32'(i), 8'h12, 1, 0);
        do_cycle(0, 0, 0, 1, 0);
        do_cycle(0, 0, 0, 1, 0);

        // Flush while FULL with a beat offered.
        do_cycle(1, 32'h300, 8'h20, 0, 0);
        do_cycle(1, 32'h301, 8'h21, 0, 0);
        do_cycle(1, 32'hDEAD, 8'h22, 0, 1);
        do_cycle(0, 0, 0, 1, 0);

        // Flush coinciding with an output transfer at ONE.
        do_cycle(1, 32'h400, 8'h30, 1, 0);
        do_cycle(0, 0, 0, 1, 1);
        do_cycle(0, 0, 0, 1, 0);

        // Asynchronous reset mid-stream while FULL.
        do_cycle(1, 32'h500, 8'h40, 0, 0);
        do_cycle(1, 32'h501, 8'h41, 0, 0);
        #2 rst_i = 1'b0;
        #1;
        q.delete();
        check_eq("async_rst_data", 64'(out_data), 64'h0);
        check_outputs();
        @(negedge clk);
        rst_i = 1'b1;
        do_cycle(1, 32'hABC, 8'h50, 1, 0);
        do_cycle(0, 0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom % 4) != 0, $urandom, 8'($urandom),
                     ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    function automatic logic [2:0] C_BUBBW_ext();
        return C_BUBW;
    endfunction

endmodule : tb_pipe_stage_skid
`default_nettype wire
